// File: rtl/dual_ahb_ram_if.sv
// Bus bundle for the two AHB3-Lite ports of dual_ahb_ram.
// Every signal is a two-element array: index 0 is the data port, index 1 the instruction port.
interface dual_ahb_ram_if #(
  parameter int AW = 12
);
  logic [AW-1:0] s_haddr_i     [2];
  logic [31:0]   s_hwdata_i    [2];
  logic [2:0]    s_hburst_i    [2];
  logic          s_hmastlock_i [2];
  logic [3:0]    s_hprot_i     [2];
  logic [2:0]    s_hsize_i     [2];
  logic [1:0]    s_htrans_i    [2];
  logic          s_hwrite_i    [2];
  logic          s_hsel_i      [2];
  logic [31:0]   s_hrdata_o    [2];
  logic          s_hready_o    [2];
  logic          s_hresp_o     [2];

  modport slave (
    input  s_haddr_i, s_hwdata_i, s_hburst_i, s_hmastlock_i, s_hprot_i,
           s_hsize_i, s_htrans_i, s_hwrite_i, s_hsel_i,
    output s_hrdata_o, s_hready_o, s_hresp_o
  );

  modport master (
    output s_haddr_i, s_hwdata_i, s_hburst_i, s_hmastlock_i, s_hprot_i,
           s_hsize_i, s_htrans_i, s_hwrite_i, s_hsel_i,
    input  s_hrdata_o, s_hready_o, s_hresp_o
  );
endinterface

// File: rtl/dual_ahb_ram.sv
// Two-port zero-wait-state AHB3-Lite RAM sharing one little-endian word array.
// Port 0 is the data port, port 1 the instruction port; port 0 wins overlapping byte writes.
module dual_ahb_ram #(
  parameter int MEM_SIZE   = 32'h1000,
  parameter bit SIMULATION = 1'b0,
  parameter bit ENABLE_LOG = 1'b0,
  parameter     LABEL      = "RAM"
) (
  input  logic          s_clk_i,
  input  logic          s_resetn_i,
  dual_ahb_ram_if.slave s_bus
);
  localparam int AW    = $clog2(MEM_SIZE);
  localparam int WORDS = MEM_SIZE / 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } port_state_t;

  logic [31:0]   r_memory [WORDS];

  port_state_t   r_state  [2];
  logic          r_write  [2];
  logic [1:0]    r_size   [2];
  logic [AW-1:0] r_addr   [2];
  logic          r_hready [2];
  logic          r_hresp  [2];

  logic          accept   [2];
  logic          bad      [2];
  logic [3:0]    lanes    [2];
  logic [31:0]   mask     [2];
  logic          we       [2];
  logic [AW-3:0] widx     [2];
  logic [31:0]   merged1;
  logic [31:0]   base0;
  logic [31:0]   merged0;

  // The simulation-only parameters and AHB sideband inputs carry no function here.
  wire unused_inputs = &{1'b0, SIMULATION, ENABLE_LOG, LABEL[0],
                         s_bus.s_hburst_i[0], s_bus.s_hburst_i[1],
                         s_bus.s_hmastlock_i[0], s_bus.s_hmastlock_i[1],
                         s_bus.s_hprot_i[0], s_bus.s_hprot_i[1],
                         s_bus.s_htrans_i[0][0], s_bus.s_htrans_i[1][0]};

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      accept[p] = s_bus.s_hsel_i[p] & s_bus.s_htrans_i[p][1] & r_hready[p];
      bad[p]    = (s_bus.s_hsize_i[p] > 3'd2)
               | ((s_bus.s_hsize_i[p] == 3'd1) & s_bus.s_haddr_i[p][0])
               | ((s_bus.s_hsize_i[p] == 3'd2) & (s_bus.s_haddr_i[p][1:0] != 2'd0));
      lanes[p]  = 4'b1111;
      case (r_size[p])
        2'd0:    lanes[p] = 4'b0001 << r_addr[p][1:0];
        2'd1:    lanes[p] = r_addr[p][1] ? 4'b1100 : 4'b0011;
        default: lanes[p] = 4'b1111;
      endcase
      mask[p] = {{8{lanes[p][3]}}, {8{lanes[p][2]}}, {8{lanes[p][1]}}, {8{lanes[p][0]}}};
      we[p]   = (r_state[p] == ST_ACCESS) & r_write[p];
      widx[p] = r_addr[p][AW-1:2];
      s_bus.s_hrdata_o[p] = ((r_state[p] == ST_ACCESS) && !r_write[p]) ? r_memory[widx[p]] : 32'd0;
      s_bus.s_hready_o[p] = r_hready[p];
      s_bus.s_hresp_o[p]  = r_hresp[p];
    end
  end

  // Port 0 merges on top of port 1's result when both hit the same word.
  always_comb begin
    merged1 = (r_memory[widx[1]] & ~mask[1]) | (s_bus.s_hwdata_i[1] & mask[1]);
    base0   = (we[1] && (widx[0] == widx[1])) ? merged1 : r_memory[widx[0]];
    merged0 = (base0 & ~mask[0]) | (s_bus.s_hwdata_i[0] & mask[0]);
  end

  always_ff @(posedge s_clk_i) begin
    if (we[1]) r_memory[widx[1]] <= merged1;
    if (we[0]) r_memory[widx[0]] <= merged0;
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      for (int p = 0; p < 2; p++) begin
        r_state[p]  <= ST_IDLE;
        r_write[p]  <= 1'b0;
        r_size[p]   <= 2'd0;
        r_addr[p]   <= '0;
        r_hready[p] <= 1'b1;
        r_hresp[p]  <= 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (r_state[p] == ST_ERR1) begin
          r_state[p]  <= ST_ERR2;
          r_hready[p] <= 1'b1;
          r_hresp[p]  <= 1'b1;
        end else if (accept[p] && bad[p]) begin
          r_state[p]  <= ST_ERR1;
          r_hready[p] <= 1'b0;
          r_hresp[p]  <= 1'b1;
        end else if (accept[p]) begin
          r_state[p]  <= ST_ACCESS;
          r_write[p]  <= s_bus.s_hwrite_i[p];
          r_size[p]   <= s_bus.s_hsize_i[p][1:0];
          r_addr[p]   <= s_bus.s_haddr_i[p];
          r_hready[p] <= 1'b1;
          r_hresp[p]  <= 1'b0;
        end else begin
          r_state[p]  <= ST_IDLE;
          r_hready[p] <= 1'b1;
          r_hresp[p]  <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_dual_ahb_ram.sv
// Directed self-checking bench for dual_ahb_ram: reads, writes, lane merging, errors and reset.
module tb_dual_ahb_ram;
  logic r_ver_clk;
  logic r_ver_rstn;
  int   assertions;
  int   failures;

  dual_ahb_ram_if #(.AW(12)) bus ();

  dual_ahb_ram #(
    .MEM_SIZE  (32'h1000),
    .SIMULATION(1'b0),
    .ENABLE_LOG(1'b0),
    .LABEL     ("RAM")
  ) dut (
    .s_clk_i   (r_ver_clk),
    .s_resetn_i(r_ver_rstn),
    .s_bus     (bus)
  );

  initial begin
    r_ver_clk = 1'b0;
    forever #5 r_ver_clk = ~r_ver_clk;
  end

  task automatic step();
    @(posedge r_ver_clk);
    #1;
  endtask

  task automatic applyStimulus(input int p, input logic [11:0] addr, input logic wr,
                               input logic [2:0] size, input logic [1:0] trans);
    bus.s_hsel_i[p]   = 1'b1;
    bus.s_haddr_i[p]  = addr;
    bus.s_hwrite_i[p] = wr;
    bus.s_hsize_i[p]  = size;
    bus.s_htrans_i[p] = trans;
  endtask

  task automatic idle(input int p);
    bus.s_htrans_i[p] = 2'b00;
    bus.s_hwrite_i[p] = 1'b0;
  endtask

  task automatic write_data(input int p, input logic [11:0] addr, input logic [2:0] size,
                            input logic [31:0] data);
    applyStimulus(p, addr, 1'b1, size, 2'b10);
    step();
    bus.s_hwdata_i[p] = data;
    idle(p);
    step();
  endtask

  task automatic read_word(input int p, input logic [11:0] addr, output logic [31:0] data,
                           output logic rdy, output logic resp);
    applyStimulus(p, addr, 1'b0, 3'd2, 2'b10);
    step();
    data = bus.s_hrdata_o[p];
    rdy  = bus.s_hready_o[p];
    resp = bus.s_hresp_o[p];
    idle(p);
  endtask

  task automatic test_reset();
    for (int p = 0; p < 2; p++) begin
      assertions++;
      if (bus.s_hready_o[p] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL reset_hready port%0d: got %b expected 1", p, bus.s_hready_o[p]);
      end
      assertions++;
      if (bus.s_hresp_o[p] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_hresp port%0d: got %b expected 0", p, bus.s_hresp_o[p]);
      end
      assertions++;
      if (bus.s_hrdata_o[p] !== 32'd0) begin
        failures++;
        $display("[TB] FAIL reset_hrdata port%0d: got %h expected 0", p, bus.s_hrdata_o[p]);
      end
    end
  endtask

  task automatic test_word_rw();
    logic [31:0] d;
    logic        rdy, resp;
    write_data(0, 12'h010, 3'd2, 32'hDEADBEEF);
    read_word(1, 12'h010, d, rdy, resp);
    assertions++;
    if (d !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL word_rw_data: got %h expected deadbeef", d);
    end
    assertions++;
    if (rdy !== 1'b1 || resp !== 1'b0) begin
      failures++;
      $display("[TB] FAIL word_rw_status: got hready %b hresp %b expected 1 0", rdy, resp);
    end
  endtask

  task automatic test_byte_half();
    logic [31:0] d;
    logic        rdy, resp;
    write_data(0, 12'h010, 3'd2, 32'h11223344);
    write_data(0, 12'h013, 3'd0, 32'hAA000000);
    read_word(0, 12'h010, d, rdy, resp);
    assertions++;
    if (d !== 32'hAA223344) begin
      failures++;
      $display("[TB] FAIL byte_write: got %h expected aa223344", d);
    end
    write_data(1, 12'h012, 3'd1, 32'h55660000);
    read_word(1, 12'h010, d, rdy, resp);
    assertions++;
    if (d !== 32'h55663344) begin
      failures++;
      $display("[TB] FAIL half_write: got %h expected 55663344", d);
    end
  endtask

  task automatic test_read_during_write();
    logic [31:0] d;
    logic        rdy, resp;
    write_data(0, 12'h000, 3'd2, 32'h12345678);
    applyStimulus(0, 12'h000, 1'b1, 3'd2, 2'b10);
    applyStimulus(1, 12'h000, 1'b0, 3'd2, 2'b10);
    step();
    bus.s_hwdata_i[0] = 32'hCAFEF00D;
    d = bus.s_hrdata_o[1];
    idle(0);
    idle(1);
    assertions++;
    if (d !== 32'h12345678) begin
      failures++;
      $display("[TB] FAIL rdw_old: got %h expected 12345678", d);
    end
    step();
    read_word(1, 12'h000, d, rdy, resp);
    assertions++;
    if (d !== 32'hCAFEF00D) begin
      failures++;
      $display("[TB] FAIL rdw_new: got %h expected cafef00d", d);
    end
  endtask

  task automatic test_dual_write();
    logic [31:0] d;
    logic        rdy, resp;
    applyStimulus(0, 12'h020, 1'b1, 3'd2, 2'b10);
    applyStimulus(1, 12'h020, 1'b1, 3'd2, 2'b10);
    step();
    bus.s_hwdata_i[0] = 32'h11111111;
    bus.s_hwdata_i[1] = 32'h22222222;
    idle(0);
    idle(1);
    step();
    read_word(0, 12'h020, d, rdy, resp);
    assertions++;
    if (d !== 32'h11111111) begin
      failures++;
      $display("[TB] FAIL dual_word: got %h expected 11111111", d);
    end
    applyStimulus(0, 12'h020, 1'b1, 3'd0, 2'b10);
    applyStimulus(1, 12'h021, 1'b1, 3'd0, 2'b10);
    step();
    bus.s_hwdata_i[0] = 32'h000000AB;
    bus.s_hwdata_i[1] = 32'h0000CD00;
    idle(0);
    idle(1);
    step();
    read_word(1, 12'h020, d, rdy, resp);
    assertions++;
    if (d !== 32'h1111CDAB) begin
      failures++;
      $display("[TB] FAIL dual_merge: got %h expected 1111cdab", d);
    end
  endtask

  task automatic test_error();
    logic [11:0] err_addr [2];
    logic [2:0]  err_size [2];
    logic [31:0] exp_mem  [2];
    int          widx     [2];
    err_addr = '{12'h002, 12'h010};
    err_size = '{3'd2, 3'd3};
    exp_mem  = '{32'hCAFEF00D, 32'h55663344};
    widx     = '{0, 4};
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, err_addr[k], 1'b1, err_size[k], 2'b10);
      step();
      bus.s_hwdata_i[0] = 32'hFFFFFFFF;
      idle(0);
      assertions++;
      if (bus.s_hready_o[0] !== 1'b0 || bus.s_hresp_o[0] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL err%0d_cycle1: got hready %b hresp %b expected 0 1",
                 k, bus.s_hready_o[0], bus.s_hresp_o[0]);
      end
      step();
      assertions++;
      if (bus.s_hready_o[0] !== 1'b1 || bus.s_hresp_o[0] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL err%0d_cycle2: got hready %b hresp %b expected 1 1",
                 k, bus.s_hready_o[0], bus.s_hresp_o[0]);
      end
      step();
      assertions++;
      if (bus.s_hready_o[0] !== 1'b1 || bus.s_hresp_o[0] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL err%0d_after: got hready %b hresp %b expected 1 0",
                 k, bus.s_hready_o[0], bus.s_hresp_o[0]);
      end
      assertions++;
      if (dut.r_memory[widx[k]] !== exp_mem[k]) begin
        failures++;
        $display("[TB] FAIL err%0d_mem: got %h expected %h", k, dut.r_memory[widx[k]], exp_mem[k]);
      end
    end
  endtask

  task automatic test_idle();
    write_data(0, 12'h004, 3'd2, 32'h04040404);
    write_data(0, 12'h008, 3'd2, 32'h08080808);
    applyStimulus(0, 12'h004, 1'b1, 3'd2, 2'b10);
    bus.s_hsel_i[0] = 1'b0;
    step();
    bus.s_hwdata_i[0] = 32'hFFFFFFFF;
    applyStimulus(0, 12'h004, 1'b1, 3'd2, 2'b01);
    step();
    idle(0);
    step();
    assertions++;
    if (dut.r_memory[1] !== 32'h04040404) begin
      failures++;
      $display("[TB] FAIL idle_no_write: got %h expected 04040404", dut.r_memory[1]);
    end
    assertions++;
    if (bus.s_hready_o[0] !== 1'b1 || bus.s_hresp_o[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_status: got hready %b hresp %b expected 1 0",
               bus.s_hready_o[0], bus.s_hresp_o[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_words [3];
    logic [31:0] d;
    exp_words = '{32'hCAFEF00D, 32'h04040404, 32'h08080808};
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 12'(k * 4), 1'b0, 3'd2, 2'b10);
      step();
      d = bus.s_hrdata_o[1];
      assertions++;
      if (d !== exp_words[k]) begin
        failures++;
        $display("[TB] FAIL b2b_read%0d: got %h expected %h", k, d, exp_words[k]);
      end
    end
    idle(1);
  endtask

  task automatic test_reset_mid_write();
    applyStimulus(0, 12'h008, 1'b1, 3'd2, 2'b10);
    step();
    bus.s_hwdata_i[0] = 32'h99999999;
    idle(0);
    r_ver_rstn = 1'b0;
    #2;
    r_ver_rstn = 1'b1;
    step();
    step();
    assertions++;
    if (dut.r_memory[2] !== 32'h08080808) begin
      failures++;
      $display("[TB] FAIL reset_mid_write: got %h expected 08080808", dut.r_memory[2]);
    end
    assertions++;
    if (bus.s_hready_o[0] !== 1'b1 || bus.s_hresp_o[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_status: got hready %b hresp %b expected 1 0",
               bus.s_hready_o[0], bus.s_hresp_o[0]);
    end
  endtask

  initial begin
    assertions = 0;
    failures   = 0;
    r_ver_rstn = 1'b1;
    for (int p = 0; p < 2; p++) begin
      bus.s_hsel_i[p]      = 1'b1;
      bus.s_haddr_i[p]     = '0;
      bus.s_hwdata_i[p]    = '0;
      bus.s_hburst_i[p]    = '0;
      bus.s_hmastlock_i[p] = 1'b0;
      bus.s_hprot_i[p]     = '0;
      bus.s_hsize_i[p]     = 3'd2;
      bus.s_htrans_i[p]    = 2'b00;
      bus.s_hwrite_i[p]    = 1'b0;
    end
    #1;
    r_ver_rstn = 1'b0;
    step();
    step();
    test_reset();
    r_ver_rstn = 1'b1;
    step();
    test_word_rw();
    test_byte_half();
    test_read_during_write();
    test_dual_write();
    test_error();
    test_idle();
    test_back_to_back();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
